seq_mul_engine: RTL and testbench

SEQ_MUL_ENGINE -- requirements
Module: seq_mul_engine

---
 rtl/mul_pkg.sv | 20 ++
 rtl/seq_mul_engine_if.sv | 34 +++
 rtl/mul_core.sv | 58 +++++
 rtl/seq_mul_engine.sv | 155 +++++++++++++++
 tb/tb_seq_mul_engine.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the sequential multiply engine.
//   state_t      - engine FSM states, also exported on the debug port
//   DEF_*        - default parameter values used by the engine, core and bus
package mul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL   = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_OP_W     = 16;
  localparam int DEF_N_PAIRS  = 16;
  localparam int DEF_AW       = 8;
  localparam int DEF_SRC_BASE = 0;
  localparam int DEF_DST_BASE = 64;

endpackage

// File: rtl/seq_mul_engine_if.sv
// seq_mul_engine_if: control handshake plus byte-wide data-memory bus.
//   start       run request (low) / idle-and-acknowledge (high)
//   signed_mode 1 = two's-complement operands, sampled when a run launches
//   done        high once every product of the run has been written
//   mem_addr    byte address; mem_rdata returns that byte in the same cycle
//   mem_wr_en   one-byte write strobe, mem_wdata the byte written
// Handshake: the controller drops start to request a run and keeps it low
// until done is seen; raising start then acknowledges done and returns the
// engine to idle. start changes while a run is in progress are ignored.
interface seq_mul_engine_if
  import mul_pkg::*;
#(
  parameter int AW = DEF_AW
);
  logic          start;
  logic          signed_mode;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  // engine side
  modport slave (
    input  start, signed_mode, mem_rdata,
    output done, mem_addr, mem_wr_en, mem_wdata
  );

  // controller / memory side
  modport master (
    output start, signed_mode, mem_rdata,
    input  done, mem_addr, mem_wr_en, mem_wdata
  );
endinterface

// File: rtl/mul_core.sv
// mul_core: iterative shift-add multiplier, one partial product per step.
//   clk, reset   clock and synchronous active-high reset
//   load         capture a, c and signed_mode, clear the accumulator
//   step         add one partial product (OP_W steps give the full result)
//   a, c         operands; product = c * a
//   product      2*OP_W-bit accumulator, exact after OP_W steps
module mul_core
  import mul_pkg::*;
#(
  parameter int OP_W = DEF_OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              signed_mode,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   c,
  output logic [2*OP_W-1:0] product
);
  localparam int IW = $clog2(OP_W);

  logic [2*OP_W-1:0] mcand_q;
  logic [2*OP_W-1:0] acc_q;
  logic [OP_W-1:0]   mplier_q;
  logic [IW-1:0]     idx_q;
  logic              sgn_q;
  logic              last_bit;

  // In two's complement the multiplier MSB carries negative weight, so the
  // final partial product is subtracted instead of added.
  assign last_bit = (idx_q == IW'(OP_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      idx_q    <= '0;
      sgn_q    <= 1'b0;
    end else if (load) begin
      mcand_q  <= signed_mode ? {{OP_W{a[OP_W-1]}}, a} : {{OP_W{1'b0}}, a};
      acc_q    <= '0;
      mplier_q <= c;
      idx_q    <= '0;
      sgn_q    <= signed_mode;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_q <= (sgn_q && last_bit) ? acc_q - mcand_q : acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      idx_q    <= idx_q + 1'b1;
    end
  end

  assign product = acc_q;
endmodule

// File: rtl/seq_mul_engine.sv
// seq_mul_engine: reads N_PAIRS operand pairs from byte memory, multiplies
// each with mul_core and writes the 2*OP_W-bit products back, big-endian.
//   clk, reset   clock and synchronous active-high reset
//   bus          seq_mul_engine_if slave: start/signed_mode/done + memory
//   dbg_state_o  current FSM state
module seq_mul_engine
  import mul_pkg::*;
#(
  parameter int OP_W     = DEF_OP_W,
  parameter int N_PAIRS  = DEF_N_PAIRS,
  parameter int AW       = DEF_AW,
  parameter int SRC_BASE = DEF_SRC_BASE,
  parameter int DST_BASE = DEF_DST_BASE
) (
  input  logic             clk,
  input  logic             reset,
  seq_mul_engine_if.slave  bus,
  output state_t           dbg_state_o
);
  localparam int B   = OP_W / 8;
  localparam int NB2 = 2 * B;
  localparam int CW  = $clog2(OP_W);
  localparam int PW  = $clog2(N_PAIRS + 1);

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [PW-1:0]       pair_q;
  logic [AW-1:0]       src_ptr_q;
  logic [AW-1:0]       dst_ptr_q;
  logic [AW-1:0]       mem_addr_q;
  logic                mem_wr_en_q;
  logic                done_q;
  logic                arm_q;
  logic                sgn_q;
  logic [2*OP_W-9:0]   ab_q;       // bytes read so far for the current pair
  logic [2*OP_W-1:0]   ab_next;    // {A, C} once the last byte arrives
  logic [2*OP_W-1:0]   product;
  logic                load_last;
  logic [7:0]          wr_byte;

  assign ab_next   = {ab_q, bus.mem_rdata};
  assign load_last = (state_q == LOAD) && (cnt_q == CW'(NB2 - 1));

  // The core latches the operands from the final read byte directly, so MUL
  // starts stepping on the very next cycle.
  mul_core #(.OP_W(OP_W)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (load_last),
    .step       (state_q == MUL),
    .signed_mode(sgn_q),
    .a          (ab_next[2*OP_W-1:OP_W]),
    .c          (ab_next[OP_W-1:0]),
    .product    (product)
  );

  // Store byte cnt_q of the product, MSB first; zero whenever not writing.
  always_comb begin
    wr_byte = '0;
    if (mem_wr_en_q) begin
      wr_byte = product[(NB2 - 1 - int'(cnt_q)) * 8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pair_q      <= '0;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      mem_addr_q  <= '0;
      mem_wr_en_q <= 1'b0;
      done_q      <= 1'b0;
      arm_q       <= 1'b0;
      sgn_q       <= 1'b0;
      ab_q        <= '0;
    end else begin
      case (state_q)
        // A launch needs start seen high first, so a reset with start held
        // low does not restart the run on its own.
        IDLE: begin
          if (bus.start) begin
            arm_q <= 1'b1;
          end else if (arm_q) begin
            arm_q      <= 1'b0;
            state_q    <= LOAD;
            sgn_q      <= bus.signed_mode;
            cnt_q      <= '0;
            pair_q     <= '0;
            src_ptr_q  <= AW'(SRC_BASE);
            dst_ptr_q  <= AW'(DST_BASE);
            mem_addr_q <= AW'(SRC_BASE);
          end
        end
        LOAD: begin
          ab_q      <= ab_next[2*OP_W-9:0];
          src_ptr_q <= src_ptr_q + 1'b1;
          if (cnt_q == CW'(NB2 - 1)) begin
            state_q <= MUL;
            cnt_q   <= '0;
          end else begin
            cnt_q      <= cnt_q + 1'b1;
            mem_addr_q <= src_ptr_q + 1'b1;
          end
        end
        MUL: begin
          if (cnt_q == CW'(OP_W - 1)) begin
            state_q     <= STORE;
            cnt_q       <= '0;
            mem_addr_q  <= dst_ptr_q;
            mem_wr_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STORE: begin
          dst_ptr_q <= dst_ptr_q + 1'b1;
          if (cnt_q == CW'(NB2 - 1)) begin
            mem_wr_en_q <= 1'b0;
            cnt_q       <= '0;
            pair_q      <= pair_q + 1'b1;
            if (pair_q == PW'(N_PAIRS - 1)) begin
              state_q <= DONE;
            end else begin
              state_q    <= LOAD;
              mem_addr_q <= src_ptr_q;
            end
          end else begin
            cnt_q      <= cnt_q + 1'b1;
            mem_addr_q <= dst_ptr_q + 1'b1;
          end
        end
        // done rises one cycle after entering DONE and holds until start
        // acknowledges it.
        DONE: begin
          if (bus.start) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            arm_q   <= 1'b1;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.done      = done_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wr_en = mem_wr_en_q;
  assign bus.mem_wdata = wr_byte;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_seq_mul_engine.sv
module tb_seq_mul_engine;
  import mul_pkg::*;

  localparam int W0   = 16;
  localparam int NP0  = 16;
  localparam int W1   = 8;
  localparam int NP1  = 4;
  localparam int CYC0 = NP0 * (4 * (W0 / 8) + W0) + 1;
  localparam int CYC1 = NP1 * (4 * (W1 / 8) + W1) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_mul_engine_if #(.AW(8)) b0 ();
  seq_mul_engine_if #(.AW(8)) b1 ();
  state_t st0, st1;

  seq_mul_engine #(.OP_W(W0), .N_PAIRS(NP0), .AW(8), .SRC_BASE(0), .DST_BASE(64)) dut0 (
    .clk(clk), .reset(rst), .bus(b0.slave), .dbg_state_o(st0)
  );
  seq_mul_engine #(.OP_W(W1), .N_PAIRS(NP1), .AW(8), .SRC_BASE(0), .DST_BASE(254)) dut1 (
    .clk(clk), .reset(rst), .bus(b1.slave), .dbg_state_o(st1)
  );

  // ---------------- memories ----------------
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] img0 [256];
  logic [7:0] img1 [256];
  logic [7:0] eimg0 [256];
  logic [7:0] eimg1 [256];
  bit fill0 = 1'b0;
  bit fill1 = 1'b0;

  assign b0.mem_rdata = mem0[b0.mem_addr];
  assign b1.mem_rdata = mem1[b1.mem_addr];

  always @(posedge clk) begin
    if (fill0) mem0 <= img0;
    else if (b0.mem_wr_en === 1'b1) mem0[b0.mem_addr] <= b0.mem_wdata;
    if (fill1) mem1 <= img1;
    else if (b1.mem_wr_en === 1'b1) mem1[b1.mem_addr] <= b1.mem_wdata;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int wr0 = 0;
  int wr1 = 0;
  logic [15:0] exp0_q[$];
  logic [15:0] exp1_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write strobe is matched, in order, against the expected {addr, byte}.
  always @(negedge clk) begin
    if (b0.mem_wr_en === 1'b1) begin
      wr0++;
      check_val("wr0_expected", 64'(exp0_q.size() != 0), 64'd1);
      if (exp0_q.size() != 0) check_val("wr0", 64'({b0.mem_addr, b0.mem_wdata}), 64'(exp0_q.pop_front()));
    end
    if (b1.mem_wr_en === 1'b1) begin
      wr1++;
      check_val("wr1_expected", 64'(exp1_q.size() != 0), 64'd1);
      if (exp1_q.size() != 0) check_val("wr1", 64'({b1.mem_addr, b1.mem_wdata}), 64'(exp1_q.pop_front()));
    end
  end

  // ---------------- reference model ----------------
  // Works on a copy of the memory image pair by pair: fetch big-endian
  // operands, multiply as integers, write the big-endian product back.
  task automatic model(input int sel, input bit sgn);
    int b, w, np, dst, ad;
    longint a, c, p;
    logic [7:0] im [256];
    logic [7:0] by;
    b   = (sel == 0) ? W0 / 8 : W1 / 8;
    w   = 8 * b;
    np  = (sel == 0) ? NP0 : NP1;
    dst = (sel == 0) ? 64 : 254;
    for (int i = 0; i < 256; i++) im[i] = (sel == 0) ? img0[i] : img1[i];
    for (int j = 0; j < np; j++) begin
      a = 0;
      c = 0;
      for (int k = 0; k < b; k++) begin
        a = (a << 8) | longint'(im[(2 * j * b + k) % 256]);
        c = (c << 8) | longint'(im[((2 * j + 1) * b + k) % 256]);
      end
      if (sgn) begin
        if (a >= (longint'(1) << (w - 1))) a = a - (longint'(1) << w);
        if (c >= (longint'(1) << (w - 1))) c = c - (longint'(1) << w);
      end
      p = c * a;
      for (int k = 0; k < 2 * b; k++) begin
        by = 8'(p >> (8 * (2 * b - 1 - k)));
        ad = (dst + 2 * b * j + k) % 256;
        im[ad] = by;
        if (sel == 0) exp0_q.push_back({8'(ad), by});
        else          exp1_q.push_back({8'(ad), by});
      end
    end
    for (int i = 0; i < 256; i++) begin
      if (sel == 0) eimg0[i] = im[i];
      else          eimg1[i] = im[i];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_start(input int sel, input logic v);
    if (sel == 0) b0.start = v; else b1.start = v;
  endtask

  task automatic set_sgn(input int sel, input logic v);
    if (sel == 0) b0.signed_mode = v; else b1.signed_mode = v;
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? b0.done : b1.done;
  endfunction

  function automatic logic [31:0] word0(input int a);
    return {mem0[a], mem0[a + 1], mem0[a + 2], mem0[a + 3]};
  endfunction

  task automatic prepare(input int sel, input bit sgn);
    model(sel, sgn);
    @(negedge clk);
    if (sel == 0) fill0 = 1'b1; else fill1 = 1'b1;
    @(posedge clk);
    #1;
    fill0 = 1'b0;
    fill1 = 1'b0;
  endtask

  task automatic rand_image(input int sel);
    for (int i = 0; i < 256; i++) begin
      if (sel == 0) img0[i] = 8'($urandom);
      else          img1[i] = 8'($urandom);
    end
  endtask

  task automatic run(input int sel, input bit sgn, input int toggle_at, input int exp_cyc);
    int cycles;
    int nbad;
    bit seen;
    @(negedge clk);
    set_sgn(sel, sgn);
    set_start(sel, 1'b0);
    @(posedge clk);
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 2000) begin
      @(posedge clk);
      cycles++;
      #1;
      if (toggle_at > 0 && cycles == toggle_at) begin
        set_start(sel, 1'b1);
        set_sgn(sel, ~sgn);
      end
      if (toggle_at > 0 && cycles == toggle_at + 3) set_start(sel, 1'b0);
      if (get_done(sel) === 1'b1) seen = 1'b1;
    end
    check_val("done_cycle", 64'(cycles), 64'(exp_cyc));
    repeat (3) begin
      @(negedge clk);
      check_val("done_hold", 64'(get_done(sel)), 64'd1);
    end
    check_val("queue_drained", 64'((sel == 0) ? exp0_q.size() : exp1_q.size()), 64'd0);
    nbad = 0;
    for (int i = 0; i < 256; i++) begin
      if (sel == 0) begin
        if (mem0[i] !== eimg0[i]) nbad++;
      end else begin
        if (mem1[i] !== eimg1[i]) nbad++;
      end
    end
    check_val("image_bad_bytes", 64'(nbad), 64'd0);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    check_val("done_clear", 64'(get_done(sel)), 64'd0);
    check_val("idle_after_ack", 64'((sel == 0) ? st0 : st1), 64'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    bit sgn;
    rst = 1'b1;
    b0.start = 1'b1;
    b1.start = 1'b1;
    b0.signed_mode = 1'b0;
    b1.signed_mode = 1'b0;
    for (int i = 0; i < 256; i++) begin
      img0[i] = 8'h00;
      img1[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_done", 64'(b0.done), 64'd0);
    check_val("rst_wr_en", 64'(b0.mem_wr_en), 64'd0);
    check_val("rst_addr", 64'(b0.mem_addr), 64'd0);
    check_val("rst_wdata", 64'(b0.mem_wdata), 64'd0);
    check_val("rst_state", 64'(st0), 64'(IDLE));
    check_val("rst_done1", 64'(b1.done), 64'd0);
    check_val("rst_state1", 64'(st1), 64'(IDLE));
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // (-3, 7) in pair 0, everything else zero
    img0[0] = 8'hFF; img0[1] = 8'hFD; img0[2] = 8'h00; img0[3] = 8'h07;
    prepare(0, 1'b1);
    run(0, 1'b1, 0, CYC0);
    check_val("neg3x7", 64'(word0(64)), 64'hFFFFFFEB);
    check_val("zero_pair1", 64'(word0(68)), 64'h0);

    // corner operands, signed then unsigned on the same file
    for (int i = 0; i < 256; i++) img0[i] = 8'h00;
    img0[0] = 8'h80; img0[1] = 8'h00; img0[2]  = 8'h80; img0[3]  = 8'h00;
    img0[4] = 8'hFF; img0[5] = 8'hFF; img0[6]  = 8'hFF; img0[7]  = 8'hFF;
    img0[8] = 8'h7F; img0[9] = 8'hFF; img0[10] = 8'h80; img0[11] = 8'h00;
    prepare(0, 1'b1);
    run(0, 1'b1, 0, CYC0);
    check_val("s_min_x_min", 64'(word0(64)), 64'h40000000);
    check_val("s_m1_x_m1", 64'(word0(68)), 64'h00000001);
    check_val("s_max_x_min", 64'(word0(72)), 64'hC0008000);
    prepare(0, 1'b0);
    run(0, 1'b0, 0, CYC0);
    check_val("u_ffff_sq", 64'(word0(68)), 64'hFFFE0001);
    check_val("u_7fff_x_8000", 64'(word0(72)), 64'h3FFF8000);

    // reset in the middle of a run
    rand_image(0);
    prepare(0, 1'b1);
    @(negedge clk);
    b0.signed_mode = 1'b1;
    b0.start = 1'b0;
    @(posedge clk);
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort_wr_en", 64'(b0.mem_wr_en), 64'd0);
    check_val("abort_done", 64'(b0.done), 64'd0);
    check_val("abort_state", 64'(st0), 64'(IDLE));
    rst = 1'b0;
    exp0_q.delete();
    w = wr0;
    repeat (40) @(posedge clk);
    #1;
    check_val("no_wr_after_abort", 64'(wr0 - w), 64'd0);
    check_val("no_relaunch", 64'(st0), 64'(IDLE));
    @(negedge clk);
    b0.start = 1'b1;
    @(posedge clk);
    rand_image(0);
    prepare(0, 1'b1);
    run(0, 1'b1, 0, CYC0);

    // back-to-back random files; the first one sees start/signed_mode wiggle
    for (int r = 0; r < 10; r++) begin
      rand_image(0);
      sgn = 1'($urandom_range(0, 1));
      prepare(0, sgn);
      run(0, sgn, (r == 0) ? $urandom_range(50, 300) : 0, CYC0);
    end

    // 8-bit engine with wrapping destination
    rand_image(1);
    img1[0] = 8'h80;
    img1[1] = 8'h80;
    prepare(1, 1'b1);
    run(1, 1'b1, 20, CYC1);
    check_val("w8_byte254", 64'(mem1[254]), 64'h40);
    check_val("w8_byte255", 64'(mem1[255]), 64'h00);
    rand_image(1);
    prepare(1, 1'b0);
    run(1, 1'b0, 0, CYC1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
